mag_timer: RTL and testbench

- Cook-time countdown timer for the magnetron controller.
- Accepts keypad BCD digits while the magnetron is off and holds an mm:ss time.
- Counts down one second per prescaled tick while the magnetron is on.
- Drives timer_done back into the magnetron set/reset logic, which treats it as a reset condition, and pulses a one-cycle beep request on expiry.

---
 rtl/mag_pkg.sv | 22 ++
 rtl/mag_if.sv | 26 ++
 rtl/mag_bcd_down_digit.sv | 30 +++
 rtl/mag_timer.sv | 86 ++++++++
 tb/tb_mag_timer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mag_pkg.sv
// Shared constants and types for the magnetron cook-time countdown timer.
package mag_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned TICK_DIV_DEFAULT = 1000;
    localparam int unsigned PRESC_W_DEFAULT  = 10;

    localparam logic [BCD_W-1:0] SEC_TENS_WRAP = 4'd5;
    localparam logic [BCD_W-1:0] ONES_WRAP     = 4'd9;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } display_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/mag_if.sv
// Keypad/control inputs and mm:ss display outputs of the cook timer.
interface mag_if;
    import mag_pkg::*;

    logic             clearn;
    logic             mag_on;
    logic             digit_valid;
    logic [BCD_W-1:0] digit;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             timer_done;
    logic             done_pulse;

    modport master (
        output clearn, mag_on, digit_valid, digit,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse
    );

    modport slave (
        input  clearn, mag_on, digit_valid, digit,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse
    );

endinterface

// File: rtl/mag_bcd_down_digit.sv
// One BCD digit register: clear, decrement-with-borrow, or parallel load.
module mag_bcd_down_digit
    import mag_pkg::*;
#(
    parameter logic [BCD_W-1:0] WRAP = ONES_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load_en,
    input  logic [BCD_W-1:0] load_val,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] value,
    output logic             borrow_out
);

    // Decrement and load are mutually exclusive at the top level.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (borrow_in) begin
            value <= (value == '0) ? WRAP : value - BCD_W'(1);
        end else if (load_en) begin
            value <= load_val;
        end
    end

    assign borrow_out = borrow_in & (value == '0);

endmodule

// File: rtl/mag_timer.sv
// Cook-time countdown: keypad shift entry, 1 s prescaled BCD countdown, done flag and beep pulse.
module mag_timer
    import mag_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned PRESC_W  = PRESC_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    mag_if.slave bus
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic [BCD_W-1:0]   mt, mo, st, so;
    logic               b_so, b_st, b_mo, b_mt;
    display_t           disp;
    logic               clr, entry, run, wrap, dec, one_left;
    logic               done, pulse, next_done;

    assign disp     = display_t'({mt, mo, st, so});
    assign clr      = ~bus.clearn;
    assign entry    = bus.clearn & ~bus.mag_on & bus.digit_valid & is_bcd(bus.digit);
    assign run      = bus.clearn & bus.mag_on & ~done;
    assign wrap     = (presc == PRESC_MAX);
    assign dec      = run & wrap;
    assign one_left = (disp == display_t'(16'h0001));

    // Predict whether the digits become all-zero on this edge.
    always_comb begin
        next_done = done;
        if (clr) begin
            next_done = 1'b1;
        end else if (dec) begin
            next_done = one_left;
        end else if (entry) begin
            next_done = ({mo, st, so, bus.digit} == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            done  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            done  <= next_done;
            pulse <= dec & one_left;
            if (clr) begin
                presc <= '0;
            end else if (run) begin
                presc <= wrap ? '0 : presc + PRESC_W'(1);
            end
        end
    end

    mag_bcd_down_digit #(.WRAP(ONES_WRAP)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clr), .load_en(entry), .load_val(bus.digit),
        .borrow_in(dec), .value(so), .borrow_out(b_so)
    );

    mag_bcd_down_digit #(.WRAP(SEC_TENS_WRAP)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clr), .load_en(entry), .load_val(so),
        .borrow_in(b_so), .value(st), .borrow_out(b_st)
    );

    mag_bcd_down_digit #(.WRAP(ONES_WRAP)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clr), .load_en(entry), .load_val(st),
        .borrow_in(b_st), .value(mo), .borrow_out(b_mo)
    );

    // Never borrows: countdown stops at 00:00.
    mag_bcd_down_digit #(.WRAP(ONES_WRAP)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clr), .load_en(entry), .load_val(mo),
        .borrow_in(b_mo), .value(mt), .borrow_out(b_mt)
    );

    assign bus.min_tens   = mt;
    assign bus.min_ones   = mo;
    assign bus.sec_tens   = st;
    assign bus.sec_ones   = so;
    assign bus.timer_done = done;
    assign bus.done_pulse = pulse;

endmodule

// File: tb/tb_mag_timer.sv
// Directed bench for mag_timer with a 4-cycle second.
module tb_mag_timer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    mag_if bus ();

    mag_timer #(.TICK_DIV(4), .PRESC_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] shown();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic key(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick();
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic load(input logic [15:0] t);
        bus.mag_on = 1'b0;
        bus.clearn = 1'b0;
        tick();
        bus.clearn = 1'b1;
        key(t[15:12]);
        key(t[11:8]);
        key(t[7:4]);
        key(t[3:0]);
    endtask

    initial begin
        rst             = 1'b1;
        bus.clearn      = 1'b1;
        bus.mag_on      = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;

        // Reset
        tick(2);
        rst = 1'b0;
        check("rst_digits", shown(), 16'h0000);
        check("rst_done", 16'(bus.timer_done), 16'h1);
        check("rst_pulse", 16'(bus.done_pulse), 16'h0);
        bus.mag_on = 1'b1;
        tick(6);
        check("idle_on_digits", shown(), 16'h0000);
        check("idle_on_pulse", 16'(bus.done_pulse), 16'h0);
        bus.mag_on = 1'b0;

        // Entry
        key(4'd1);
        check("entry_1", shown(), 16'h0001);
        check("entry_1_done", 16'(bus.timer_done), 16'h0);
        key(4'd3);
        key(4'd0);
        check("entry_130", shown(), 16'h0130);
        key(4'd12);
        check("entry_bad_digit", shown(), 16'h0130);
        bus.mag_on = 1'b1;
        key(4'd5);
        check("entry_while_on", shown(), 16'h0130);
        bus.mag_on = 1'b0;

        // Countdown borrow
        load(16'h0100);
        check("load_0100", shown(), 16'h0100);
        check("load_pulse", 16'(bus.done_pulse), 16'h0);
        bus.mag_on = 1'b1;
        tick(3);
        check("pre_tick", shown(), 16'h0100);
        tick(1);
        check("tick1_059", shown(), 16'h0059);
        tick(4);
        check("tick2_058", shown(), 16'h0058);
        load(16'h1000);
        bus.mag_on = 1'b1;
        tick(4);
        check("tick_0959", shown(), 16'h0959);

        // Expiry
        load(16'h0002);
        bus.mag_on = 1'b1;
        tick(4);
        check("exp_001", shown(), 16'h0001);
        check("exp_001_pulse", 16'(bus.done_pulse), 16'h0);
        tick(3);
        check("exp_hold_001", shown(), 16'h0001);
        tick(1);
        check("exp_000", shown(), 16'h0000);
        check("exp_done", 16'(bus.timer_done), 16'h1);
        check("exp_pulse", 16'(bus.done_pulse), 16'h1);
        tick(1);
        check("exp_pulse_once", 16'(bus.done_pulse), 16'h0);
        tick(6);
        check("exp_stay", shown(), 16'h0000);
        check("exp_stay_pulse", 16'(bus.done_pulse), 16'h0);

        // Pause/resume keeps the partial second
        load(16'h0005);
        bus.mag_on = 1'b1;
        tick(2);
        bus.mag_on = 1'b0;
        tick(10);
        check("pause_hold", shown(), 16'h0005);
        bus.mag_on = 1'b1;
        tick(1);
        check("resume_1", shown(), 16'h0005);
        tick(1);
        check("resume_004", shown(), 16'h0004);

        // mag_on dropping on the wrap edge
        load(16'h0003);
        bus.mag_on = 1'b1;
        tick(3);
        bus.mag_on = 1'b0;
        tick(1);
        check("drop_on_wrap", shown(), 16'h0003);
        bus.mag_on = 1'b1;
        tick(1);
        check("wrap_after_resume", shown(), 16'h0002);

        // Reset mid-countdown
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid", shown(), 16'h0000);
        check("rst_mid_pulse", 16'(bus.done_pulse), 16'h0);
        check("rst_mid_done", 16'(bus.timer_done), 16'h1);

        // 0:90 then clear with a concurrent strobe
        load(16'h0090);
        check("load_0090", shown(), 16'h0090);
        bus.mag_on = 1'b1;
        tick(4);
        check("tick_0089", shown(), 16'h0089);
        bus.clearn      = 1'b0;
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd7;
        tick(1);
        bus.clearn      = 1'b1;
        bus.digit_valid = 1'b0;
        check("clr_digits", shown(), 16'h0000);
        check("clr_done", 16'(bus.timer_done), 16'h1);
        check("clr_pulse", 16'(bus.done_pulse), 16'h0);
        bus.mag_on = 1'b0;
        tick(1);
        check("clr_after", shown(), 16'h0000);
        check("clr_after_pulse", 16'(bus.done_pulse), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
